nts_descriptor_buffer: RTL and testbench

//  Downstream consumer of the host-receive NTS descriptor (46b, level wr held until ack).

---
 rtl/nts_descriptor_buffer_pkg.sv | 28 ++
 rtl/nts_desc_fifo.sv | 61 ++++++
 rtl/nts_descriptor_buffer.sv | 105 ++++++++++
 tb/tb_nts_descriptor_buffer.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nts_descriptor_buffer_pkg.sv
// Host-receive package: descriptor layout, buffer sizing
// and output FSM encodings for the NTS descriptor buffer.
package nts_descriptor_buffer_pkg;

  localparam int DESC_W        = 46;
  localparam int DEPTH         = 4;
  localparam int ADDR_W        = 2;
  localparam int ACK_TIMEOUT   = 255;
  localparam int TIMER_W       = 8;

  localparam int LOOKUP_EN_BIT = 18;
  localparam int OUTPORT_MSB   = 17;
  localparam int OUTPORT_LSB   = 9;
  localparam int BUFID_MSB     = 8;
  localparam int BUFID_LSB     = 0;

  typedef logic [DESC_W-1:0] desc_t;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } out_state_t;

  function automatic logic needs_lookup(input desc_t d);
    return d[LOOKUP_EN_BIT];
  endfunction

endpackage

// File: rtl/nts_desc_fifo.sv
// Small register FIFO with a show-ahead head entry.
// Full/empty come from the registered occupancy count.
module nts_desc_fifo
  import nts_descriptor_buffer_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  desc_t             iv_data,
  input  logic              i_pop,
  output desc_t             ov_head,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   ov_usedw
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  desc_t             mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   count;
  logic              do_push;
  logic              do_pop;

  assign o_full   = (count == FULL_CNT);
  assign o_empty  = (count == '0);
  assign do_push  = i_push && !o_full;
  assign do_pop   = i_pop && !o_empty;
  assign ov_head  = mem[rptr];
  assign ov_usedw = count;

  // Storage write; contents need no reset since count gates reads
  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wptr] <= iv_data;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nts_descriptor_buffer.sv
// Accepts host-receive NTS descriptors, queues them, and routes
// each to the FLT (lookup) or straight to forwarding (direct).
module nts_descriptor_buffer
  import nts_descriptor_buffer_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  desc_t             iv_nts_descriptor,
  input  logic              i_nts_descriptor_wr,
  output logic              o_nts_descriptor_ack,
  output desc_t             ov_lookup_descriptor,
  output logic              o_lookup_wr,
  input  logic              i_lookup_ack,
  output desc_t             ov_direct_descriptor,
  output logic              o_direct_wr,
  output logic [ADDR_W:0]   ov_fifo_usedw,
  output logic [15:0]       ov_debug_in_cnt,
  output logic [15:0]       ov_debug_timeout_cnt
);

  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  desc_t              head;
  out_state_t         state;
  logic [TIMER_W-1:0] timer;

  // The ack cycle masks wr so a held request is not taken twice
  assign push = i_nts_descriptor_wr
             && !o_nts_descriptor_ack
             && !fifo_full;
  assign pop  = (state == IDLE) && !fifo_empty;

  nts_desc_fifo u_fifo (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_push   (push),
    .iv_data  (iv_nts_descriptor),
    .i_pop    (pop),
    .ov_head  (head),
    .o_full   (fifo_full),
    .o_empty  (fifo_empty),
    .ov_usedw (ov_fifo_usedw)
  );

  // Input handshake: one-cycle ack per accepted descriptor
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_nts_descriptor_ack <= 1'b0;
      ov_debug_in_cnt      <= '0;
    end else begin
      o_nts_descriptor_ack <= push;
      if (push) begin
        ov_debug_in_cnt <= ov_debug_in_cnt + 16'd1;
      end
    end
  end

  // Output FSM: route head to FLT or forwarding, with ack timeout
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state                <= IDLE;
      timer                <= '0;
      o_lookup_wr          <= 1'b0;
      ov_lookup_descriptor <= '0;
      o_direct_wr          <= 1'b0;
      ov_direct_descriptor <= '0;
      ov_debug_timeout_cnt <= '0;
    end else begin
      o_direct_wr          <= 1'b0;
      ov_direct_descriptor <= '0;
      unique case (state)
        IDLE: begin
          if (pop) begin
            if (needs_lookup(head)) begin
              ov_lookup_descriptor <= head;
              o_lookup_wr          <= 1'b1;
              timer                <= '0;
              state                <= WAIT_ACK;
            end else begin
              ov_direct_descriptor <= head;
              o_direct_wr          <= 1'b1;
            end
          end
        end
        WAIT_ACK: begin
          if (i_lookup_ack) begin
            o_lookup_wr          <= 1'b0;
            ov_lookup_descriptor <= '0;
            state                <= IDLE;
          end else if (timer == TIMER_W'(ACK_TIMEOUT)) begin
            o_lookup_wr          <= 1'b0;
            ov_lookup_descriptor <= '0;
            ov_debug_timeout_cnt <= ov_debug_timeout_cnt + 16'd1;
            state                <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nts_descriptor_buffer.sv
// Scenario bench for nts_descriptor_buffer: scoreboard queue
// of accepted descriptors checked against both output paths.
module tb_nts_descriptor_buffer;
  import nts_descriptor_buffer_pkg::*;

  logic            i_clk = 1'b0;
  logic            i_rst;
  desc_t           iv_nts_descriptor;
  logic            i_nts_descriptor_wr;
  logic            o_nts_descriptor_ack;
  desc_t           ov_lookup_descriptor;
  logic            o_lookup_wr;
  logic            i_lookup_ack;
  desc_t           ov_direct_descriptor;
  logic            o_direct_wr;
  logic [ADDR_W:0] ov_fifo_usedw;
  logic [15:0]     ov_debug_in_cnt;
  logic [15:0]     ov_debug_timeout_cnt;

  int    total = 0;
  int    bad   = 0;
  desc_t exp_q[$];
  int    n_deliv = 0;
  int    exp_in  = 0;
  int    exp_to  = 0;
  bit    flt_en  = 0;
  int    flt_lat = 1;
  logic  auto_ack = 1'b0;
  logic  man_ack  = 1'b0;

  assign i_lookup_ack = auto_ack | man_ack;

  always #5 i_clk = ~i_clk;

  nts_descriptor_buffer dut (
    .i_clk                (i_clk),
    .i_rst                (i_rst),
    .iv_nts_descriptor    (iv_nts_descriptor),
    .i_nts_descriptor_wr  (i_nts_descriptor_wr),
    .o_nts_descriptor_ack (o_nts_descriptor_ack),
    .ov_lookup_descriptor (ov_lookup_descriptor),
    .o_lookup_wr          (o_lookup_wr),
    .i_lookup_ack         (i_lookup_ack),
    .ov_direct_descriptor (ov_direct_descriptor),
    .o_direct_wr          (o_direct_wr),
    .ov_fifo_usedw        (ov_fifo_usedw),
    .ov_debug_in_cnt      (ov_debug_in_cnt),
    .ov_debug_timeout_cnt (ov_debug_timeout_cnt)
  );

  // output monitor: every new delivery pops the scoreboard
  initial begin
    desc_t e;
    logic  prev_lw;
    prev_lw = 1'b0;
    forever begin
      @(negedge i_clk);
      if (o_direct_wr === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL mon_direct unexpected got=%h", ov_direct_descriptor);
        end else begin
          e = exp_q.pop_front();
          n_deliv++;
          if (ov_direct_descriptor !== e) begin
            bad++;
            $display("FAIL mon_direct got=%h exp=%h", ov_direct_descriptor, e);
          end
        end
      end
      if (o_lookup_wr === 1'b1 && !prev_lw) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL mon_lookup unexpected got=%h", ov_lookup_descriptor);
        end else begin
          e = exp_q.pop_front();
          n_deliv++;
          if (ov_lookup_descriptor !== e) begin
            bad++;
            $display("FAIL mon_lookup got=%h exp=%h", ov_lookup_descriptor, e);
          end
        end
      end
      prev_lw = o_lookup_wr;
    end
  end

  // FLT model: acks after flt_lat cycles of wr when enabled
  initial begin
    int hc;
    hc = 0;
    forever begin
      @(negedge i_clk);
      auto_ack = 1'b0;
      if (flt_en && o_lookup_wr) begin
        hc++;
        if (hc >= flt_lat) begin
          auto_ack = 1'b1;
          hc = 0;
        end
      end else begin
        hc = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1, "watchdog");
  end

  task automatic wait_ack(input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge i_clk);
      if (o_nts_descriptor_ack) begin
        ok = 1;
        break;
      end
    end
  endtask

  // producer holds wr through the ack cycle, drops after next edge
  task automatic send(input desc_t d, output bit ok);
    iv_nts_descriptor   = d;
    i_nts_descriptor_wr = 1'b1;
    exp_q.push_back(d);
    wait_ack(50, ok);
    if (ok) begin
      exp_in++;
      @(posedge i_clk);
      #1;
      i_nts_descriptor_wr = 1'b0;
    end
  endtask

  task automatic drain(input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge i_clk);
      if (exp_q.size() == 0 && !o_lookup_wr) begin
        ok = 1;
        break;
      end
    end
  endtask

  function automatic desc_t mk(input bit lk, input logic [8:0] bid);
    desc_t d;
    d = desc_t'({$urandom(), $urandom()});
    d[LOOKUP_EN_BIT] = lk;
    d[BUFID_MSB:BUFID_LSB] = bid;
    return d;
  endfunction

  task automatic test_reset;
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    total++;
    if ({o_nts_descriptor_ack, o_lookup_wr, o_direct_wr,
         ov_lookup_descriptor, ov_direct_descriptor, ov_fifo_usedw,
         ov_debug_in_cnt, ov_debug_timeout_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_outputs ack=%b lwr=%b dwr=%b usedw=%0d exp all 0",
               o_nts_descriptor_ack, o_lookup_wr, o_direct_wr, ov_fifo_usedw);
    end
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);
    total++;
    if ({o_lookup_wr, o_direct_wr, ov_fifo_usedw} !== '0) begin
      bad++;
      $display("FAIL reset_release lwr=%b dwr=%b usedw=%0d exp 0",
               o_lookup_wr, o_direct_wr, ov_fifo_usedw);
    end
  endtask

  task automatic test_lookup_one;
    desc_t d;
    d = '0;
    d[LOOKUP_EN_BIT] = 1'b1;
    d[BUFID_MSB:BUFID_LSB] = 9'h05;
    @(negedge i_clk);
    iv_nts_descriptor   = d;
    i_nts_descriptor_wr = 1'b1;
    exp_q.push_back(d);
    @(negedge i_clk);
    total++;
    if (o_nts_descriptor_ack !== 1'b1 || o_lookup_wr !== 1'b0) begin
      bad++;
      $display("FAIL lk1_ack ack=%b lwr=%b exp ack=1 lwr=0",
               o_nts_descriptor_ack, o_lookup_wr);
    end
    exp_in++;
    i_nts_descriptor_wr = 1'b0;
    @(negedge i_clk);
    total++;
    if (o_lookup_wr !== 1'b1 || ov_lookup_descriptor !== d ||
        o_nts_descriptor_ack !== 1'b0) begin
      bad++;
      $display("FAIL lk1_wr lwr=%b desc=%h ack=%b exp lwr=1 desc=%h ack=0",
               o_lookup_wr, ov_lookup_descriptor, o_nts_descriptor_ack, d);
    end
    repeat (3) @(negedge i_clk);
    total++;
    if (o_lookup_wr !== 1'b1) begin
      bad++;
      $display("FAIL lk1_hold lwr=%b exp 1", o_lookup_wr);
    end
    man_ack = 1'b1;
    @(negedge i_clk);
    man_ack = 1'b0;
    total++;
    if (o_lookup_wr !== 1'b0 || ov_lookup_descriptor !== '0) begin
      bad++;
      $display("FAIL lk1_release lwr=%b desc=%h exp 0 0",
               o_lookup_wr, ov_lookup_descriptor);
    end
    total++;
    if (ov_debug_in_cnt !== 16'(exp_in)) begin
      bad++;
      $display("FAIL lk1_in_cnt got=%0d exp=%0d", ov_debug_in_cnt, exp_in);
    end
  endtask

  task automatic test_direct_one;
    desc_t d;
    d = mk(1'b0, 9'h011);
    d[OUTPORT_MSB:OUTPORT_LSB] = 9'h003;
    @(negedge i_clk);
    iv_nts_descriptor   = d;
    i_nts_descriptor_wr = 1'b1;
    exp_q.push_back(d);
    @(negedge i_clk);
    total++;
    if (o_nts_descriptor_ack !== 1'b1) begin
      bad++;
      $display("FAIL dir_ack ack=%b exp 1", o_nts_descriptor_ack);
    end
    exp_in++;
    i_nts_descriptor_wr = 1'b0;
    @(negedge i_clk);
    total++;
    if (o_direct_wr !== 1'b1 || ov_direct_descriptor !== d ||
        o_lookup_wr !== 1'b0) begin
      bad++;
      $display("FAIL dir_pulse dwr=%b desc=%h lwr=%b exp 1 %h 0",
               o_direct_wr, ov_direct_descriptor, o_lookup_wr, d);
    end
    @(negedge i_clk);
    total++;
    if (o_direct_wr !== 1'b0 || ov_direct_descriptor !== '0 ||
        o_lookup_wr !== 1'b0) begin
      bad++;
      $display("FAIL dir_single dwr=%b desc=%h lwr=%b exp 0 0 0",
               o_direct_wr, ov_direct_descriptor, o_lookup_wr);
    end
  endtask

  task automatic test_fifo_full;
    desc_t d[6];
    bit    ok;
    int    base;
    base   = n_deliv;
    flt_en = 0;
    for (int i = 0; i < 6; i++) d[i] = mk(1'b1, 9'(9'h40 + i));
    for (int i = 0; i < 5; i++) begin
      send(d[i], ok);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL full_fill_ack idx=%0d acked=0 exp 1", i);
      end
    end
    @(negedge i_clk);
    total++;
    if (ov_fifo_usedw !== 3'd4) begin
      bad++;
      $display("FAIL full_usedw got=%0d exp=4", ov_fifo_usedw);
    end
    iv_nts_descriptor   = d[5];
    i_nts_descriptor_wr = 1'b1;
    exp_q.push_back(d[5]);
    wait_ack(20, ok);
    total++;
    if (ok || ov_fifo_usedw !== 3'd4 || ov_lookup_descriptor !== d[0]) begin
      bad++;
      $display("FAIL full_refuse acked=%0d usedw=%0d desc=%h exp 0 4 %h",
               ok, ov_fifo_usedw, ov_lookup_descriptor, d[0]);
    end
    man_ack = 1'b1;
    @(negedge i_clk);
    man_ack = 1'b0;
    wait_ack(2, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL full_late_ack acked=0 exp 1 within 2 cycles");
    end
    if (!ok) wait_ack(10, ok);
    if (ok) exp_in++;
    @(posedge i_clk);
    #1;
    i_nts_descriptor_wr = 1'b0;
    flt_en  = 1;
    flt_lat = 1;
    drain(200, ok);
    total++;
    if (!ok || n_deliv - base != 6) begin
      bad++;
      $display("FAIL full_drain drained=%0d delivered=%0d exp 1 6",
               ok, n_deliv - base);
    end
    flt_en = 0;
  endtask

  task automatic test_timeout;
    desc_t d;
    bit    ok;
    int    hi;
    bit    still;
    flt_en = 0;
    d = mk(1'b1, 9'h0AA);
    send(d, ok);
    hi = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge i_clk);
      if (o_lookup_wr) hi++;
      else break;
    end
    total++;
    if (!ok || hi < ACK_TIMEOUT || hi > ACK_TIMEOUT + 1) begin
      bad++;
      $display("FAIL to_len acked=%0d wr_cycles=%0d exp %0d..%0d",
               ok, hi, ACK_TIMEOUT, ACK_TIMEOUT + 1);
    end
    exp_to++;
    total++;
    if (ov_debug_timeout_cnt !== 16'(exp_to) || ov_lookup_descriptor !== '0) begin
      bad++;
      $display("FAIL to_cnt got=%0d desc=%h exp=%0d 0",
               ov_debug_timeout_cnt, ov_lookup_descriptor, exp_to);
    end
    d = mk(1'b1, 9'h0AB);
    send(d, ok);
    still = 1;
    for (int i = 1; i <= hi; i++) begin
      @(negedge i_clk);
      if (!o_lookup_wr) still = 0;
    end
    total++;
    if (!ok || !still) begin
      bad++;
      $display("FAIL to_next acked=%0d wr_held=%0d exp 1 1", ok, still);
    end
    man_ack = 1'b1;
    @(negedge i_clk);
    man_ack = 1'b0;
    total++;
    if (o_lookup_wr !== 1'b0 || ov_debug_timeout_cnt !== 16'(exp_to)) begin
      bad++;
      $display("FAIL to_ack_wins lwr=%b cnt=%0d exp 0 %0d",
               o_lookup_wr, ov_debug_timeout_cnt, exp_to);
    end
  endtask

  task automatic test_back_to_back;
    desc_t d;
    bit    ok;
    int    nok;
    int    base;
    nok  = 0;
    base = n_deliv;
    flt_en = 1;
    for (int i = 0; i < 100; i++) begin
      flt_lat = $urandom_range(1, 3);
      d = mk(1'($urandom_range(0, 1)), 9'(i));
      send(d, ok);
      if (ok) nok++;
      repeat ($urandom_range(0, 2)) @(negedge i_clk);
    end
    total++;
    if (nok != 100) begin
      bad++;
      $display("FAIL b2b_acks got=%0d exp=100", nok);
    end
    drain(300, ok);
    total++;
    if (!ok || n_deliv - base != 100) begin
      bad++;
      $display("FAIL b2b_drain drained=%0d delivered=%0d exp 1 100",
               ok, n_deliv - base);
    end
    total++;
    if (ov_debug_in_cnt !== 16'(exp_in)) begin
      bad++;
      $display("FAIL b2b_in_cnt got=%0d exp=%0d", ov_debug_in_cnt, exp_in);
    end
    flt_en = 0;
    @(negedge i_clk);
  endtask

  task automatic test_reset_mid;
    bit ok;
    int errs;
    flt_en = 0;
    for (int i = 0; i < 4; i++) send(mk(1'b1, 9'(9'h100 + i)), ok);
    @(negedge i_clk);
    total++;
    if (ov_fifo_usedw !== 3'd3 || o_lookup_wr !== 1'b1) begin
      bad++;
      $display("FAIL rst_setup usedw=%0d lwr=%b exp 3 1",
               ov_fifo_usedw, o_lookup_wr);
    end
    #2;
    i_rst = 1'b1;
    #1;
    total++;
    if ({o_nts_descriptor_ack, o_lookup_wr, o_direct_wr,
         ov_lookup_descriptor, ov_direct_descriptor, ov_fifo_usedw,
         ov_debug_in_cnt, ov_debug_timeout_cnt} !== '0) begin
      bad++;
      $display("FAIL rst_async lwr=%b usedw=%0d in=%0d to=%0d exp all 0",
               o_lookup_wr, ov_fifo_usedw, ov_debug_in_cnt,
               ov_debug_timeout_cnt);
    end
    exp_q.delete();
    exp_in = 0;
    exp_to = 0;
    @(negedge i_clk);
    i_rst = 1'b0;
    errs = 0;
    repeat (6) begin
      @(negedge i_clk);
      if ({o_nts_descriptor_ack, o_lookup_wr, o_direct_wr,
           ov_fifo_usedw} !== '0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL rst_after bad_cycles=%0d lwr=%b usedw=%0d exp 0",
               errs, o_lookup_wr, ov_fifo_usedw);
    end
  endtask

  initial begin
    i_rst               = 1'b1;
    i_nts_descriptor_wr = 1'b0;
    iv_nts_descriptor   = '0;
    test_reset;
    test_lookup_one;
    test_direct_one;
    test_fifo_full;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
